// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the architectural PC, issues imem fetches over req/ack and buffers one word for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirects pulse fetch_misalign and park the FSM in HALT.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_misalign
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_HOLD    = 3'd2,
        S_DISCARD = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
        , S_HALT  = 3'd4
`endif
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] tgt_pc;
    logic        redir;
    logic        in_flight;

    assign redir     = redirect_valid && (state != S_IDLE);
    // imem_req is only high in FETCH/DISCARD, so this marks a request the memory still owes us
    assign in_flight = imem_req && !imem_ack;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic tgt_bad;
    logic halt_pend;   // misaligned redirect seen while draining: go to HALT once the ack lands
    assign tgt_pc  = redirect_pc;
    assign tgt_bad = (redirect_pc[1:0] != 2'b00);
`else
    assign tgt_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            imem_req       <= 1'b0;
            imem_addr      <= 32'h0;
            if_valid       <= 1'b0;
            if_instr       <= 32'h0;
            if_pc          <= 32'h0;
            if_pc_plus4    <= 32'h0;
            fetch_misalign <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            halt_pend      <= 1'b0;
`endif
        end else begin
            fetch_misalign <= 1'b0;
            if (redir) begin
                pc       <= tgt_pc;
                if_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                fetch_misalign <= tgt_bad;
                halt_pend      <= tgt_bad && in_flight;
`endif
                if (in_flight) begin
                    state <= S_DISCARD;
`ifdef FETCH_MISALIGN_TRAP_EN
                end else if (tgt_bad) begin
                    state    <= S_HALT;
                    imem_req <= 1'b0;
`endif
                end else begin
                    state     <= S_FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= tgt_pc;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        state     <= S_FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                    S_FETCH: begin
                        if (imem_ack) begin
                            if_instr    <= imem_rdata;
                            if_pc       <= imem_addr;
                            if_pc_plus4 <= imem_addr + 32'd4;
                            pc          <= pc + 32'd4;
                            if_valid    <= 1'b1;
                            imem_req    <= 1'b0;
                            state       <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (if_ready) begin
                            if_valid  <= 1'b0;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            state     <= S_FETCH;
                        end
                    end
                    S_DISCARD: begin
                        if (imem_ack) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                            if (halt_pend) begin
                                state     <= S_HALT;
                                imem_req  <= 1'b0;
                                halt_pend <= 1'b0;
                            end else
`endif
                            begin
                                state     <= S_FETCH;
                                imem_addr <= pc;
                            end
                        end
                    end
                    default: ;  // HALT: wait for reset or a redirect
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run against a program-order PC model.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ack = 1'b0;
    logic        if_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fetch_misalign;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_plus4(if_pc_plus4), .fetch_misalign(fetch_misalign)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; imem_ack = 1'b1; if_ready = 1'b1;
        step(); step();
        redirect_valid = 1'b0; imem_ack = 1'b0; if_ready = 1'b0;
        step();
        n_checks++;
        if ({imem_req, if_valid, fetch_misalign} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got req/valid/mis=%b want 000", {imem_req, if_valid, fetch_misalign});
        end
        n_checks++;
        if ({imem_addr, if_instr, if_pc, if_pc_plus4} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: got addr=%h instr=%h pc=%h pc4=%h want all 0", imem_addr, if_instr, if_pc, if_pc_plus4);
        end
    endtask

    task automatic test_stream();
        logic [31:0] a;
        imem_ack = 1'b1; if_ready = 1'b1; rst = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            a = 32'(k) * 32'd4;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== a || if_valid !== 1'b0) begin
                n_fail++; $display("FAIL stream_req%0d: got req=%b addr=%h valid=%b want 1 %h 0", k, imem_req, imem_addr, if_valid, a);
            end
            step();
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== a || if_instr !== mem_word(a) || if_pc_plus4 !== a + 32'd4 || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL stream_out%0d: got v=%b pc=%h instr=%h pc4=%h req=%b want pc=%h", k, if_valid, if_pc, if_instr, if_pc_plus4, imem_req, a);
            end
            step();
        end
    endtask

    task automatic test_stall();
        imem_ack = 1'b1; if_ready = 1'b0; rst = 1'b1;
        step(); step();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== mem_word(32'h0) || imem_req !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h req=%b want 1 0 %h 0", k, if_valid, if_pc, if_instr, imem_req, mem_word(32'h0));
            end
            step();
        end
        if_ready = 1'b1;
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got req=%b addr=%h v=%b want 1 00000004 0", imem_req, imem_addr, if_valid);
        end
    endtask

    task automatic test_discard();
        imem_ack = 1'b0; if_ready = 1'b1; rst = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
                n_fail++; $display("FAIL discard_hold%0d: got req=%b addr=%h v=%b want 1 0 0", k, imem_req, imem_addr, if_valid);
            end
            if (k == 2) imem_ack = 1'b1;
            step();
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL discard_refetch: got req=%b addr=%h v=%b want 1 00000100 0", imem_req, imem_addr, if_valid);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem_word(32'h100)) begin
            n_fail++; $display("FAIL discard_deliver: got v=%b pc=%h instr=%h want 1 00000100 %h", if_valid, if_pc, if_instr, mem_word(32'h100));
        end
    endtask

    task automatic test_hold_redirect();
        imem_ack = 1'b1; if_ready = 1'b1; rst = 1'b1;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL hold_redir: got v=%b req=%b addr=%h want 0 1 00000200", if_valid, imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_pc_plus4 !== 32'h204) begin
            n_fail++; $display("FAIL hold_redir_out: got v=%b pc=%h pc4=%h want 1 00000200 00000204", if_valid, if_pc, if_pc_plus4);
        end
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; if_ready = 1'b1; rst = 1'b1;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_req: got req=%b addr=%h want 1 fffffffc", imem_req, imem_addr);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
            n_fail++; $display("FAIL wrap_out: got v=%b pc=%h pc4=%h want 1 fffffffc 00000000", if_valid, if_pc, if_pc_plus4);
        end
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next: got req=%b addr=%h want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_misalign();
        imem_ack = 1'b1; if_ready = 1'b1; rst = 1'b1;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++;
        if (fetch_misalign !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL misalign_pulse: got mis=%b req=%b v=%b want 1 0 0", fetch_misalign, imem_req, if_valid);
        end
        step(); step(); step();
        n_checks++;
        if (fetch_misalign !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL misalign_halt: got mis=%b req=%b want 0 0", fetch_misalign, imem_req);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h104;
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
            n_fail++; $display("FAIL misalign_resume: got req=%b addr=%h want 1 00000104", imem_req, imem_addr);
        end
`else
        n_checks++;
        if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL misalign_force: got mis=%b req=%b addr=%h want 0 1 00000100", fetch_misalign, imem_req, imem_addr);
        end
`endif
    endtask

    // Model: decode must see an in-order stream starting at each redirect target.
    task automatic test_random();
        logic [31:0] exp_pc, pend_addr, hold_pc;
        bit halted, pend, hold_chk, redir_now, redir_prev, bad_prev;
        int xfers;
        imem_ack = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; rst = 1'b1;
        step();
        exp_pc = 32'h0; halted = 0; xfers = 0; pend = 0; hold_chk = 0; redir_prev = 0; bad_prev = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (pend) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin
                    n_fail++; $display("FAIL rnd_addr_stable c%0d: got req=%b addr=%h want 1 %h", cyc, imem_req, imem_addr, pend_addr);
                end
            end
            if (hold_chk) begin
                n_checks++;
                if (if_valid !== 1'b1 || if_pc !== hold_pc) begin
                    n_fail++; $display("FAIL rnd_hold c%0d: got v=%b pc=%h want 1 %h", cyc, if_valid, if_pc, hold_pc);
                end
            end
            if (redir_prev) begin
                n_checks++;
                if (if_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_squash c%0d: got v=%b want 0", cyc, if_valid);
                end
            end
            n_checks++;
            if (fetch_misalign !== (redir_prev && bad_prev)) begin
                n_fail++; $display("FAIL rnd_misalign c%0d: got %b want %b", cyc, fetch_misalign, redir_prev && bad_prev);
            end

            imem_ack  = ($urandom_range(0, 1) == 1);
            if_ready  = ($urandom_range(0, 3) != 0);
            redir_now = ($urandom_range(0, 11) == 0);
            redirect_valid = redir_now;
            redirect_pc = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 3) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));

            if (!redir_now && if_valid && if_ready) begin
                xfers++;
                n_checks++;
                if (if_pc !== exp_pc || halted) begin
                    n_fail++; $display("FAIL rnd_pc c%0d: got pc=%h halted=%b want %h", cyc, if_pc, halted, exp_pc);
                end
                n_checks++;
                if (if_instr !== mem_word(exp_pc) || if_pc_plus4 !== exp_pc + 32'd4) begin
                    n_fail++; $display("FAIL rnd_data c%0d: got instr=%h pc4=%h want %h %h", cyc, if_instr, if_pc_plus4, mem_word(exp_pc), exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
            end
            bad_prev = 0;
            if (redir_now) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                exp_pc = redirect_pc;
                halted = (redirect_pc[1:0] != 2'b00);
                bad_prev = halted;
`else
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
                halted = 0;
`endif
            end
            pend       = imem_req && !imem_ack;
            pend_addr  = imem_addr;
            hold_chk   = if_valid && !if_ready && !redir_now;
            hold_pc    = if_pc;
            redir_prev = redir_now;
            step();
        end
        redirect_valid = 1'b0;
        n_checks++;
        if (xfers < 30) begin
            n_fail++; $display("FAIL rnd_progress: got %0d transfers want >= 30", xfers);
        end
    endtask

    initial begin
        test_reset(); test_stream();
        test_reset(); test_stall();
        test_reset(); test_discard();
        test_reset(); test_hold_redirect();
        test_reset(); test_wrap();
        test_reset(); test_misalign();
        test_reset(); test_random();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
